cpu_trace_capture: RTL and testbench
====================================

# cpu_trace_capture

Observation-side counterpart to the CPU clock stimulus: while the stimulus drives the 24-bit CPU for a fixed number of cycles, this block records what the CPU produces over the same window. It counts run cycles, captures 24-bit CPU result words into a FIFO whenever the CPU flags them valid, and raises `Halt` once the cycle budget is spent. A host or bench drains the FIFO through a simple read handshake.

## Interface
- `DATA_W`, 24: captured word width; matches the CPU datapath.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `CYCLE_LIMIT`, 30: run cycles per capture window; must be at least 1.
- `Clock`  in  1: single clock; all logic is rising-edge.
- `Reset`  in  1: synchronous, active-high; clears all state.
- `Start`  in  1: one-cycle pulse that opens a capture window.
- `Valid`  in  1: CPU result qualifier.
- `Data`  in  DATA_W: CPU result word.
- `Rd_En`  in  1: pop request.
- `Rd_Data`  out  DATA_W: popped word, registered.
- `Rd_Valid`  out  1: `Rd_Data` is valid this cycle.
- `Count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `Empty`, `Full`  out  1 each: FIFO status.
- `Overflow`  out  1: sticky; a valid word was dropped.
- `Busy`  out  1: capture window is open.
- `Halt`  out  1: cycle budget is exhausted.
- `Cycle`  out  8: run-cycle counter.

## Operation
- State machine: IDLE, CAPTURE, DONE.
  - IDLE → CAPTURE on `Start`.
  - CAPTURE → DONE when `Cycle` reaches CYCLE_LIMIT−1 and that cycle completes.
  - DONE → CAPTURE on `Start`.
  - `Start` is ignored while in CAPTURE.
- Entering CAPTURE clears `Cycle` to 0 and clears `Overflow`. FIFO contents are kept.
- CAPTURE behaviour:
  - `Cycle` increments once per clock.
  - `Busy`=1.
  - Every cycle with `Valid`=1 pushes `Data`, including the final cycle.
- `Valid` outside CAPTURE is ignored: no push, no overflow.
- DONE: `Halt`=1, `Busy`=0, `Cycle` holds CYCLE_LIMIT−1.
- Push while `Full` and without a simultaneous pop: the word is dropped and `Overflow` is set. It stays set until the next window starts or `Reset`.
- Pop: `Rd_En` with `Empty`=0 gives `Rd_Data`=head word and `Rd_Valid`=1 on the next cycle.
  - `Rd_En` while `Empty` is ignored and `Rd_Valid`=0.
  - Reads are legal in every state.
- Simultaneous push and pop: both are performed and `Count` is unchanged.
  - This also applies when `Full`, so no overflow occurs.
  - When `Empty`, only the push takes effect.
- Pointers wrap modulo DEPTH. `Count` ranges 0..DEPTH. `Full` = (`Count`==DEPTH).
- `Cycle` is 8 bits wide, so CYCLE_LIMIT ≤ 256.
- Reset values:
  - state = IDLE.
  - `Count`=0, `Empty`=1, `Full`=0.
  - `Overflow`=0, `Busy`=0, `Halt`=0, `Cycle`=0.
  - `Rd_Valid`=0, `Rd_Data`=0.
- `Reset` asserted mid-window: returns to IDLE, empties the FIFO, and discards any push or pop in that cycle.

## Timing
- `Start` sampled at edge N: `Busy`=1 after edge N. The first capture occurs at edge N+1.
- Capture is sampled at CYCLE_LIMIT consecutive edges, N+1 through N+CYCLE_LIMIT.
- After edge N+CYCLE_LIMIT: `Halt`=1 and `Busy`=0.
- Push latency is 1 cycle: `Count`, `Empty`, `Full` and `Overflow` update after the capturing edge.
- Read latency is 1 cycle: `Rd_Valid` is a single-cycle pulse per accepted pop. Back-to-back pops yield one word per cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - Each entry also stores the 8-bit `Cycle` value at capture.
  - An extra output `Rd_Stamp` (out, 8) is presented alongside `Rd_Data` with the same latency. It resets to 0.
- `TRACE_TIMESTAMP_EN` undefined: no stamp storage and no `Rd_Stamp` port. All other behaviour is identical.

## Test plan
- Reset, then `Start`, then `Valid`=1 every cycle with `Data`=0x000001, 0x000002 and so on. DEPTH=16, CYCLE_LIMIT=30. Required:
  - `Halt`=1 after 30 cycles.
  - `Count`=16 and `Overflow`=1.
  - Drain returns 0x000001..0x000010 in order, then `Empty`=1.
- `Start`, then `Valid` only on cycles 3 and 7 with 0xABCDEF and 0x123456. Required:
  - `Count`=2.
  - Pops return 0xABCDEF then 0x123456.
  - With `TRACE_TIMESTAMP_EN`, `Rd_Stamp`=3 then 7.
- FIFO full, then push and `Rd_En` in the same cycle. Required:
  - `Count` stays 16 and `Overflow` stays 0.
  - Head word is returned.
  - Tail equals the new word after the full drain.
- `Rd_En` while `Empty`, and `Valid` in IDLE. Required: `Rd_Valid`=0, `Count`=0, `Overflow`=0.
- Two mid-window cases, each with `Count`=5 at cycle 10:
  - `Start` pulse: ignored, and `Halt` still rises at cycle 30.
  - `Reset` instead: IDLE, `Count`=0, `Cycle`=0, `Halt`=0.
- From DONE with 4 entries, pulse `Start`. Required:
  - `Halt`=0 and `Overflow` cleared.
  - The 4 entries are retained and popped before the new captures.

Source files
------------

// File: rtl/cpu_trace_capture_if.sv
// Bus bundle between the trace capture block and its host/CPU side.
// The slave modport is the capture block; the master modport is the host
// that drives CPU results and drains the FIFO.
// Optional feature macro: TRACE_TIMESTAMP_EN adds the Rd_Stamp return field.
interface cpu_trace_capture_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              Start;
  logic              Valid;
  logic [DATA_W-1:0] Data;
  logic              Rd_En;
  logic [DATA_W-1:0] Rd_Data;
  logic              Rd_Valid;
  logic [CNT_W-1:0]  Count;
  logic              Empty;
  logic              Full;
  logic              Overflow;
  logic              Busy;
  logic              Halt;
  logic [7:0]        Cycle;
`ifdef TRACE_TIMESTAMP_EN
  logic [7:0]        Rd_Stamp;

  modport master (
    output Start, Valid, Data, Rd_En,
    input  Rd_Data, Rd_Valid, Rd_Stamp, Count, Empty, Full, Overflow,
    input  Busy, Halt, Cycle
  );

  modport slave (
    input  Start, Valid, Data, Rd_En,
    output Rd_Data, Rd_Valid, Rd_Stamp, Count, Empty, Full, Overflow,
    output Busy, Halt, Cycle
  );
`else
  modport master (
    output Start, Valid, Data, Rd_En,
    input  Rd_Data, Rd_Valid, Count, Empty, Full, Overflow,
    input  Busy, Halt, Cycle
  );

  modport slave (
    input  Start, Valid, Data, Rd_En,
    output Rd_Data, Rd_Valid, Count, Empty, Full, Overflow,
    output Busy, Halt, Cycle
  );
`endif

endinterface

// File: rtl/cpu_trace_capture.sv
// CPU trace capture: opens a fixed-length capture window on Start, pushes
// every valid CPU result word into a FIFO while the window is open, and
// raises Halt once CYCLE_LIMIT cycles have been captured. The FIFO can be
// drained at any time through a registered read handshake.
// Optional feature macro: TRACE_TIMESTAMP_EN stores the run-cycle value with
// each word and returns it on Rd_Stamp alongside Rd_Data.
module cpu_trace_capture #(
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic                 Clock,
  input  logic                 Reset,
  cpu_trace_capture_if.slave   bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [7:0]       LAST_CYC = 8'(CYCLE_LIMIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_trace_capture: DEPTH must be a power of two and at least 2");
  end
  if (CYCLE_LIMIT < 1 || CYCLE_LIMIT > 256) begin : g_bad_limit
    $error("cpu_trace_capture: CYCLE_LIMIT must be in 1..256");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        cycle;
  logic              ovf;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // Per-cycle decisions derived from the current state and inputs
  logic              start_win_p0;
  logic              last_cyc_p0;
  logic              push_req_p0;
  logic              pop_ok_p0;
  logic              push_ok_p0;
  logic              drop_p0;

  logic              busy;
  logic              halt;

`ifdef TRACE_TIMESTAMP_EN
  logic [7:0]        mem_stamp [DEPTH];
  logic [7:0]        rd_stamp;
`endif

  // Stage 0: decode window control and FIFO push/pop qualification
  always_comb begin
    start_win_p0 = bus.Start && (state != CAPTURE);
    last_cyc_p0  = (state == CAPTURE) && (cycle == LAST_CYC);
    push_req_p0  = (state == CAPTURE) && bus.Valid;
    pop_ok_p0    = bus.Rd_En && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    push_ok_p0   = push_req_p0 && ((count != FULL_CNT) || pop_ok_p0);
    drop_p0      = push_req_p0 && !push_ok_p0;
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: Start opens a window from IDLE or DONE only
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_win_p0) state_nx = CAPTURE;
      CAPTURE: if (last_cyc_p0)  state_nx = DONE;
      DONE:    if (start_win_p0) state_nx = CAPTURE;
      default: state_nx = IDLE;
    endcase
  end

  // State-derived status outputs
  always_comb begin
    busy = 1'b0;
    halt = 1'b0;
    case (state)
      CAPTURE: busy = 1'b1;
      DONE:    halt = 1'b1;
      default: begin
        busy = 1'b0;
        halt = 1'b0;
      end
    endcase
  end

  // Run-cycle counter and sticky overflow, both restarted with each window
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cycle <= 8'd0;
      ovf   <= 1'b0;
    end else if (start_win_p0) begin
      cycle <= 8'd0;
      ovf   <= 1'b0;
    end else begin
      // Cycle holds at the final value once the window has closed
      if ((state == CAPTURE) && !last_cyc_p0) begin
        cycle <= cycle + 8'd1;
      end
      if (drop_p0) begin
        ovf <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_p0) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok_p0) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok_p0, pop_ok_p0})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Stage 1: FIFO storage write; a push coinciding with Reset is discarded
  always_ff @(posedge Clock) begin
    if (push_ok_p0 && !Reset) begin
      mem[wr_ptr] <= bus.Data;
`ifdef TRACE_TIMESTAMP_EN
      mem_stamp[wr_ptr] <= cycle;
`endif
    end
  end

  // Stage 1: registered read port; Rd_Data holds its last popped word
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef TRACE_TIMESTAMP_EN
      rd_stamp <= 8'd0;
`endif
    end else begin
      rd_valid <= pop_ok_p0;
      if (pop_ok_p0) begin
        rd_data <= mem[rd_ptr];
`ifdef TRACE_TIMESTAMP_EN
        rd_stamp <= mem_stamp[rd_ptr];
`endif
      end
    end
  end

  assign bus.Rd_Data  = rd_data;
  assign bus.Rd_Valid = rd_valid;
  assign bus.Count    = count;
  assign bus.Empty    = (count == '0);
  assign bus.Full     = (count == FULL_CNT);
  assign bus.Overflow = ovf;
  assign bus.Busy     = busy;
  assign bus.Halt     = halt;
  assign bus.Cycle    = cycle;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.Rd_Stamp = rd_stamp;
`endif

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: hand-written vector table, directed window
// scenarios, and a randomized run, all compared against a queue-based
// reference model of the capture window and FIFO.
module tb_cpu_trace_capture;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;
  localparam int LIMIT  = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_trace_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  cpu_trace_capture #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .CYCLE_LIMIT(LIMIT)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [7:0]        sq[$];
  logic              m_busy = 1'b0;
  logic              m_halt = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_rdv  = 1'b0;
  logic [DATA_W-1:0] m_rdd  = '0;
  logic [7:0]        m_rds  = '0;
  int                m_cyc  = 0;

  typedef struct {
    logic              start;
    logic              valid;
    logic              rd_en;
    logic [DATA_W-1:0] data;
    int                cnt;
    logic              rdv;
    logic [DATA_W-1:0] rdd;
    logic              busy;
    int                cyc;
    logic              ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge worth of the capture rules to the model
  task automatic model_update();
    logic [7:0] stamp;
    if (rst) begin
      mq.delete();
      sq.delete();
      m_busy = 1'b0;
      m_halt = 1'b0;
      m_ovf  = 1'b0;
      m_rdv  = 1'b0;
      m_rdd  = '0;
      m_rds  = '0;
      m_cyc  = 0;
      return;
    end
    m_rdv = 1'b0;
    if (bus.Rd_En && mq.size() > 0) begin
      m_rdv = 1'b1;
      m_rdd = mq.pop_front();
      m_rds = sq.pop_front();
    end
    if (m_busy && bus.Valid) begin
      if (mq.size() < DEPTH) begin
        stamp = 8'(m_cyc);
        mq.push_back(bus.Data);
        sq.push_back(stamp);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_busy) begin
      if (m_cyc == LIMIT - 1) begin
        m_busy = 1'b0;
        m_halt = 1'b1;
      end else begin
        m_cyc++;
      end
    end else if (bus.Start) begin
      m_busy = 1'b1;
      m_halt = 1'b0;
      m_cyc  = 0;
      m_ovf  = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("m_count", bus.Count, mq.size());
    check("m_empty", bus.Empty, (mq.size() == 0));
    check("m_full", bus.Full, (mq.size() == DEPTH));
    check("m_ovf", bus.Overflow, m_ovf);
    check("m_busy", bus.Busy, m_busy);
    check("m_halt", bus.Halt, m_halt);
    check("m_cycle", bus.Cycle, m_cyc);
    check("m_rdv", bus.Rd_Valid, m_rdv);
    check("m_rdd", bus.Rd_Data, m_rdd);
`ifdef TRACE_TIMESTAMP_EN
    check("m_rds", bus.Rd_Stamp, m_rds);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_in(input logic s, input logic v, input logic [DATA_W-1:0] d, input logic r);
    bus.Start = s;
    bus.Valid = v;
    bus.Data  = d;
    bus.Rd_En = r;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [DATA_W-1:0] exp);
    set_in(1'b0, 1'b0, '0, 1'b1);
    step();
    check({name, "_rdv"}, bus.Rd_Valid, 1'b1);
    check({name, "_rdd"}, bus.Rd_Data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{start:0, valid:0, rd_en:1, data:24'h0,      cnt:0, rdv:0, rdd:24'h0,      busy:0, cyc:0, ovf:0};
    tbl[1] = '{start:0, valid:1, rd_en:0, data:24'h111111, cnt:0, rdv:0, rdd:24'h0,      busy:0, cyc:0, ovf:0};
    tbl[2] = '{start:1, valid:0, rd_en:0, data:24'h0,      cnt:0, rdv:0, rdd:24'h0,      busy:1, cyc:0, ovf:0};
    tbl[3] = '{start:0, valid:1, rd_en:0, data:24'hABCDEF, cnt:1, rdv:0, rdd:24'h0,      busy:1, cyc:1, ovf:0};
    tbl[4] = '{start:0, valid:1, rd_en:1, data:24'h123456, cnt:1, rdv:1, rdd:24'hABCDEF, busy:1, cyc:2, ovf:0};
    tbl[5] = '{start:1, valid:0, rd_en:1, data:24'h0,      cnt:0, rdv:1, rdd:24'h123456, busy:1, cyc:3, ovf:0};
    tbl[6] = '{start:0, valid:0, rd_en:1, data:24'h0,      cnt:0, rdv:0, rdd:24'h0,      busy:1, cyc:4, ovf:0};
    tbl[7] = '{start:0, valid:1, rd_en:1, data:24'h00000A, cnt:1, rdv:0, rdd:24'h0,      busy:1, cyc:5, ovf:0};
    tbl[8] = '{start:0, valid:0, rd_en:0, data:24'h0,      cnt:1, rdv:0, rdd:24'h0,      busy:1, cyc:6, ovf:0};

    set_in(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count", bus.Count, 0);
    check("rst_empty", bus.Empty, 1'b1);
    check("rst_full", bus.Full, 1'b0);
    check("rst_ovf", bus.Overflow, 1'b0);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_halt", bus.Halt, 1'b0);
    check("rst_cycle", bus.Cycle, 0);
    check("rst_rdv", bus.Rd_Valid, 1'b0);
    check("rst_rdd", bus.Rd_Data, 0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].rd_en);
      step();
      check($sformatf("tbl%0d_count", i), bus.Count, tbl[i].cnt);
      check($sformatf("tbl%0d_rdv", i), bus.Rd_Valid, tbl[i].rdv);
      if (tbl[i].rdv) check($sformatf("tbl%0d_rdd", i), bus.Rd_Data, tbl[i].rdd);
      check($sformatf("tbl%0d_busy", i), bus.Busy, tbl[i].busy);
      check($sformatf("tbl%0d_cycle", i), bus.Cycle, tbl[i].cyc);
      check($sformatf("tbl%0d_ovf", i), bus.Overflow, tbl[i].ovf);
    end

    // Full window of valid words: overflow after 16, drain in order
    do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int k = 0; k < LIMIT; k++) begin
      set_in(1'b0, 1'b1, DATA_W'(k + 1), 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, '0, 1'b0);
    check("fill_halt", bus.Halt, 1'b1);
    check("fill_busy", bus.Busy, 1'b0);
    check("fill_count", bus.Count, 16);
    check("fill_ovf", bus.Overflow, 1'b1);
    check("fill_cycle", bus.Cycle, LIMIT - 1);
    for (int k = 0; k < DEPTH; k++) pop_expect("drain", DATA_W'(k + 1));
    set_in(1'b0, 1'b0, '0, 1'b0);
    step();
    check("drain_empty", bus.Empty, 1'b1);
    check("drain_rdv_off", bus.Rd_Valid, 1'b0);

    // Sparse captures on cycles 3 and 7, restarted from DONE
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    check("sparse_ovf_clr", bus.Overflow, 1'b0);
    for (int k = 0; k < LIMIT; k++) begin
      set_in(1'b0, (k == 3 || k == 7), (k == 3) ? 24'hABCDEF : 24'h123456, 1'b0);
      step();
    end
    check("sparse_count", bus.Count, 2);
    check("sparse_halt", bus.Halt, 1'b1);
    pop_expect("sparse0", 24'hABCDEF);
`ifdef TRACE_TIMESTAMP_EN
    check("sparse0_stamp", bus.Rd_Stamp, 3);
`endif
    pop_expect("sparse1", 24'h123456);
`ifdef TRACE_TIMESTAMP_EN
    check("sparse1_stamp", bus.Rd_Stamp, 7);
`endif
    set_in(1'b0, 1'b0, '0, 1'b0);
    step();

    // Full FIFO with simultaneous push and pop
    do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      set_in(1'b0, 1'b1, DATA_W'(24'h100 + k), 1'b0);
      step();
    end
    check("full_flag", bus.Full, 1'b1);
    set_in(1'b0, 1'b1, 24'hFEED01, 1'b1);
    step();
    check("pp_count", bus.Count, 16);
    check("pp_ovf", bus.Overflow, 1'b0);
    check("pp_rdv", bus.Rd_Valid, 1'b1);
    check("pp_head", bus.Rd_Data, 24'h100);
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = DEPTH + 1; k < LIMIT; k++) step();
    check("pp_halt", bus.Halt, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      pop_expect("pp_drain", (k < DEPTH - 1) ? DATA_W'(24'h101 + k) : 24'hFEED01);

    // Mid-window Start is ignored
    do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b1, DATA_W'(24'h500 + k), 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("mid_count", bus.Count, 5);
    check("mid_cycle", bus.Cycle, 10);
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 18; k++) step();
    check("mid_halt_pre", bus.Halt, 1'b0);
    check("mid_busy_pre", bus.Busy, 1'b1);
    step();
    check("mid_halt", bus.Halt, 1'b1);
    check("mid_busy", bus.Busy, 1'b0);

    // Mid-window Reset, then Valid and Rd_En while idle and empty
    do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b1, DATA_W'(24'h600 + k), 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("mrst_count_pre", bus.Count, 5);
    set_in(1'b0, 1'b1, 24'h777777, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", bus.Busy, 1'b0);
    check("mrst_count", bus.Count, 0);
    check("mrst_cycle", bus.Cycle, 0);
    check("mrst_halt", bus.Halt, 1'b0);
    check("mrst_rdv", bus.Rd_Valid, 1'b0);
    set_in(1'b0, 1'b1, 24'h888888, 1'b1);
    step();
    check("idle_rdv", bus.Rd_Valid, 1'b0);
    check("idle_count", bus.Count, 0);
    check("idle_ovf", bus.Overflow, 1'b0);

    // Restart from DONE with 4 retained entries and overflow set
    do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int k = 0; k < 20; k++) begin
      set_in(1'b0, 1'b1, DATA_W'(24'hE00 + k), 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    check("rs_ovf_pre", bus.Overflow, 1'b1);
    for (int k = 0; k < 12; k++) pop_expect("rs_pop", DATA_W'(24'hE00 + k));
    set_in(1'b0, 1'b0, '0, 1'b0);
    step();
    check("rs_count_pre", bus.Count, 4);
    set_in(1'b1, 1'b0, '0, 1'b0);
    step();
    check("rs_halt", bus.Halt, 1'b0);
    check("rs_ovf", bus.Overflow, 1'b0);
    check("rs_count", bus.Count, 4);
    set_in(1'b0, 1'b1, 24'h0000C1, 1'b0);
    step();
    set_in(1'b0, 1'b1, 24'h0000C2, 1'b0);
    step();
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int k = 2; k < LIMIT; k++) step();
    for (int k = 0; k < 4; k++) pop_expect("rs_old", DATA_W'(24'hE0C + k));
    pop_expect("rs_new0", 24'h0000C1);
    pop_expect("rs_new1", 24'h0000C2);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      set_in(($urandom % 25) == 0, ($urandom % 2) == 1, DATA_W'($urandom), ($urandom % 5) < 2);
      rst = (($urandom % 300) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
